// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding and line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit for a captured UART word; odd = 1 inverts the even (XOR) result.
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  odd,
  output logic                  parity
);

  assign parity = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or two stop bits,
// each bit held for exactly one baud_tick interval.
//
// state     | meaning
// IDLE      | line idle, tx_ready high, accepting a word
// WAIT_TICK | word captured, line idle until the next baud_tick
// START     | start bit on the line
// DATA      | data bit bit_idx on the line
// PARITY    | parity bit on the line
// STOP      | stop bit(s) on the line
module uart_tx_frame_engine
  import uart_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      nxt_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  stop2_q;
  logic                  stop_cnt;
  logic                  parity_bit;

  assign nxt_idx = bit_idx + 1'b1;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data   (data_q),
    .odd    (par_odd_q),
    .parity (parity_bit)
  );

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      serial_out <= IDLE_LEVEL;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_idx    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          serial_out <= IDLE_LEVEL;
          tx_ready   <= 1'b1;
          if (tx_valid && tx_ready) begin
            data_q    <= tx_data;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            stop2_q   <= stop2;
            tx_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT_TICK;
          end
        end
        // A tick coincident with the transfer was seen while still in IDLE, so it never starts the frame.
        WAIT_TICK: if (baud_tick) begin
          serial_out <= ~IDLE_LEVEL;
          state      <= START;
        end
        START: if (baud_tick) begin
          bit_idx    <= '0;
          serial_out <= data_q[0];
          state      <= DATA;
        end
        DATA: if (baud_tick) begin
          if (bit_idx == LAST_IDX) begin
            bit_idx <= '0;
            if (par_en_q) begin
              serial_out <= parity_bit;
              state      <= PARITY;
            end else begin
              serial_out <= IDLE_LEVEL;
              stop_cnt   <= stop2_q;
              state      <= STOP;
            end
          end else begin
            bit_idx    <= nxt_idx;
            serial_out <= data_q[nxt_idx];
          end
        end
        PARITY: if (baud_tick) begin
          serial_out <= IDLE_LEVEL;
          stop_cnt   <= stop2_q;
          state      <= STOP;
        end
        STOP: if (baud_tick) begin
          if (stop_cnt) begin
            stop_cnt <= 1'b0;
          end else begin
            frame_done <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          serial_out <= IDLE_LEVEL;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Randomized bench for uart_tx_frame_engine; expected line bits come from a frame model
// built from the word, parity mode and stop count.
module tb_uart_tx_frame_engine;

  localparam int TDIV = 4;

  logic       UCLK;
  logic       reset;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       serial_out;
  logic       busy;
  logic       frame_done;

  logic [4:0] tx_data_w5;
  logic       tx_valid_w5;
  logic       tx_ready_w5;
  logic       parity_en_w5;
  logic       parity_odd_w5;
  logic       stop2_w5;
  logic       serial_out_w5;
  logic       busy_w5;
  logic       frame_done_w5;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_frame_engine #(.DATA_WIDTH(8)) dut (
    .UCLK       (UCLK),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  uart_tx_frame_engine #(.DATA_WIDTH(5)) dut_w5 (
    .UCLK       (UCLK),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .tx_data    (tx_data_w5),
    .tx_valid   (tx_valid_w5),
    .tx_ready   (tx_ready_w5),
    .parity_en  (parity_en_w5),
    .parity_odd (parity_odd_w5),
    .stop2      (stop2_w5),
    .serial_out (serial_out_w5),
    .busy       (busy_w5),
    .frame_done (frame_done_w5)
  );

  initial begin
    UCLK = 1'b0;
    forever #5 UCLK = ~UCLK;
  end

  initial forever begin
    @(posedge UCLK);
    cyc++;
  end

  initial begin
    int cnt;
    cnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge UCLK);
      baud_tick = (cnt == 0);
      cnt = (cnt + 1) % TDIV;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8 * TDIV; n++) begin
      @(posedge UCLK);
      if (baud_tick) begin
        ok = 1'b1;
        return;
      end
    end
    chk("tick_timeout", 32'(baud_tick), 1);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge UCLK);
      if (tx_ready) begin
        ok = 1'b1;
        return;
      end
    end
    chk("ready_timeout", 32'(tx_ready), 1);
  endtask

  // align = negedges after a tick before raising tx_valid; TDIV makes the transfer land on a tick.
  task automatic send8(input logic [7:0] d, input bit pe, input bit po, input bit s2,
                       input int align, input int abort_at);
    bit q[$];
    bit ok;
    int t0, n, ones;
    t0 = 0;
    wait_ready(ok);
    if (!ok) return;
    wait_tick(ok);
    repeat (align) @(negedge UCLK);
    tx_data = d; parity_en = pe; parity_odd = po; stop2 = s2; tx_valid = 1'b1;
    @(negedge UCLK);
    tx_valid   = 1'b0;
    tx_data    = 8'($urandom);
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
    stop2      = 1'($urandom);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_ready", 32'(tx_ready), 0);
    chk("wait_line", 32'(serial_out), 1);

    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(po ? (ones % 2 == 0) : (ones % 2 == 1));
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);

    for (int i = 0; i < q.size(); i++) begin
      wait_tick(ok);
      if (!ok) return;
      @(negedge UCLK);
      if (i == 0) t0 = cyc;
      chk("line_bit", 32'(serial_out), 32'(q[i]));
      chk("ready_low", 32'(tx_ready), 0);
      chk("no_done", 32'(frame_done), 0);
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        chk("rst_line", 32'(serial_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(tx_ready), 0);
        chk("rst_done", 32'(frame_done), 0);
        @(negedge UCLK);
        reset = 1'b1;
        #1;
        chk("rel_ready_low", 32'(tx_ready), 0);
        @(negedge UCLK);
        chk("rel_ready_high", 32'(tx_ready), 1);
        chk("rel_no_done", 32'(frame_done), 0);
        chk("rel_busy", 32'(busy), 0);
        return;
      end
    end

    n = 0;
    while (!frame_done && n < 3 * TDIV) begin
      @(negedge UCLK);
      n++;
    end
    chk("done_seen", 32'(frame_done), 1);
    chk("frame_len", cyc - t0, q.size() * TDIV);
    chk("done_ready", 32'(tx_ready), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_line", 32'(serial_out), 1);
    @(negedge UCLK);
    chk("done_pulse", 32'(frame_done), 0);
  endtask

  task automatic back_to_back_w5();
    bit exp5[$];
    bit ok;
    int n;
    exp5 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge UCLK);
    tx_data_w5 = 5'h1F; parity_en_w5 = 1'b1; parity_odd_w5 = 1'b1; stop2_w5 = 1'b0;
    tx_valid_w5 = 1'b1;
    @(negedge UCLK);
    chk("w5_accept", 32'(busy_w5), 1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < exp5.size(); i++) begin
        wait_tick(ok);
        if (!ok) return;
        @(negedge UCLK);
        chk("w5_line_bit", 32'(serial_out_w5), 32'(exp5[i]));
      end
      n = 0;
      while (!frame_done_w5 && n < 3 * TDIV) begin
        @(negedge UCLK);
        n++;
      end
      chk("w5_done_seen", 32'(frame_done_w5), 1);
      chk("w5_done_ready", 32'(tx_ready_w5), 1);
      if (f == 1) tx_valid_w5 = 1'b0;
      @(negedge UCLK);
      chk("w5_reaccept_busy", 32'(busy_w5), (f == 0) ? 1 : 0);
      chk("w5_reaccept_ready", 32'(tx_ready_w5), (f == 0) ? 0 : 1);
    end
  endtask

  initial begin
    reset = 1'b0;
    tx_data = '0; tx_valid = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    tx_data_w5 = '0; tx_valid_w5 = 1'b0; parity_en_w5 = 1'b0; parity_odd_w5 = 1'b0; stop2_w5 = 1'b0;
    repeat (3) @(negedge UCLK);
    chk("reset_line", 32'(serial_out), 1);
    chk("reset_ready", 32'(tx_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(frame_done), 0);
    reset = 1'b1;
    #1;
    chk("release_ready_low", 32'(tx_ready), 0);
    @(negedge UCLK);
    chk("release_ready_high", 32'(tx_ready), 1);
    chk("release_line", 32'(serial_out), 1);

    send8(8'hA5, 1'b0, 1'b0, 1'b0, 2, -1);
    send8(8'h07, 1'b1, 1'b0, 1'b0, 3, -1);
    send8(8'h07, 1'b1, 1'b1, 1'b0, 1, -1);
    send8(8'h00, 1'b0, 1'b0, 1'b1, 2, -1);
    send8(8'h3C, 1'b1, 1'b0, 1'b1, TDIV, -1);
    send8(8'h5A, 1'b0, 1'b0, 1'b0, 1, 5);
    for (int k = 0; k < 12; k++)
      send8(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(1, TDIV)), -1);
    back_to_back_w5();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_engine.md
UART_TX_FRAME_ENGINE -- requirements
Module: uart_tx_frame_engine

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter: IDLE_LEVEL, 1'b1, line level when idle/stop.
REQ-003 SHALL have port: UCLK  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: baud_tick  input  1  one-UCLK pulse per bit period.
REQ-006 SHALL have port: tx_data  input  DATA_WIDTH  parallel word to send.
REQ-007 SHALL have port: tx_valid  input  1  tx_data valid.
REQ-008 SHALL have port: tx_ready  output  1  engine can accept a word.
REQ-009 SHALL have port: parity_en  input  1  append parity bit.
REQ-010 SHALL have port: parity_odd  input  1  1 = odd parity, 0 = even.
REQ-011 SHALL have port: stop2  input  1  1 = two stop bits, 0 = one.
REQ-012 SHALL have port: serial_out  output  1  registered TX line.
REQ-013 SHALL have port: busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_TICK, START, DATA, PARITY, STOP.
REQ-016 SHALL assert tx_ready only in IDLE; transfer = tx_valid && tx_ready on a rising edge.
REQ-017 SHALL, on transfer, capture tx_data, parity_en, parity_odd, stop2 into internal registers and enter WAIT_TICK; later input changes do not affect the frame in flight.
REQ-018 SHALL ignore a baud_tick coincident with the transfer; WAIT_TICK holds serial_out = IDLE_LEVEL until the next baud_tick.
REQ-019 SHALL advance state only on baud_tick edges after WAIT_TICK, so every bit lasts exactly one tick interval.
REQ-020 SHALL drive serial_out = ~IDLE_LEVEL in START, registered, changing on the edge where baud_tick is sampled.
REQ-021 SHALL send data LSB first in DATA, using a $clog2(DATA_WIDTH)-bit index counting 0..DATA_WIDTH-1; on the tick ending bit DATA_WIDTH-1, go to PARITY if parity_en was captured, else STOP.
REQ-022 SHALL compute parity as the XOR of captured data bits (even) or its inverse (odd), evaluated on captured data only.
REQ-023 SHALL hold serial_out = IDLE_LEVEL in STOP for 1 tick (stop2 = 0) or 2 ticks (stop2 = 1).
REQ-024 SHALL, on the tick ending the last stop bit, pulse frame_done for one cycle, enter IDLE, and raise tx_ready in the same cycle as frame_done.
REQ-025 SHALL keep serial_out = IDLE_LEVEL while in IDLE, regardless of baud_tick.
REQ-026 SHALL define frame length in ticks as 1 + DATA_WIDTH + parity_en + (stop2 ? 2 : 1).
REQ-027 SHALL allow a transfer in the cycle frame_done is high; that new frame waits in WAIT_TICK for the next baud_tick.

Reset
REQ-028 SHALL, on reset low, immediately and asynchronously force state IDLE, serial_out = IDLE_LEVEL, tx_ready = 0, busy = 0, frame_done = 0, bit index = 0, and all captured registers = 0.
REQ-029 SHALL raise tx_ready on the first UCLK edge after reset deasserts.
REQ-030 SHALL abandon any frame in flight on reset, with no frame_done pulse.

Structure
REQ-031 SHALL take the state enum typedef and IDLE_LEVEL default from shared package uart_pkg.
REQ-032 SHALL place parity generation in sub-module uart_parity_calc (DATA_WIDTH data and odd select in, 1-bit parity out).

Verification
REQ-033 Scenario: DATA_WIDTH = 8, no parity, stop2 = 0, send 8'hA5 -> line sequence 0,1,0,1,0,0,1,0,1,1 per tick, then one frame_done pulse.
REQ-034 Scenario: send 8'h07 with even parity -> parity bit 1; with odd parity -> parity bit 0; frame is 11 ticks.
REQ-035 Scenario: stop2 = 1, send 8'h00 -> STOP lasts 2 ticks; tx_ready stays low until frame_done.
REQ-036 Scenario: transfer in the same cycle as baud_tick -> line stays 1 for that tick; start bit begins at the next tick.
REQ-037 Scenario: assert reset during DATA bit 4 -> serial_out = 1 at once, no frame_done; tx_ready = 1 one cycle after release.
REQ-038 Scenario: DATA_WIDTH = 5, send 5'h1F with parity_en = 1 and odd parity -> 5 data ones, parity 0; tx_valid held high so back-to-back frames are accepted on the frame_done cycle.
